// File: rtl/data_memory_sized.sv
// Big-endian byte-addressed data memory with byte/half/word access, a one-entry posted-store
// buffer with byte-granular load forwarding, and misalign/range error detection.
module data_memory_sized #(
  parameter int unsigned ADDR_W    = 7,
  parameter bit          ZERO_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic        err_clr,
  output logic [31:0] DM_data,
  output logic        misalign,
  output logic        range_err,
  output logic        err_sticky,
  output logic        st_pending
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned WordW    = ADDR_W - 2;
  localparam logic [7:0]  InitByte = ZERO_INIT ? 8'h00 : 8'hxx;

  // Simulation-time fill only; reset never touches the array.
  logic [7:0] mem_q [Depth] = '{default: InitByte};

  logic             buf_valid_q, buf_valid_d;
  logic [WordW-1:0] buf_waddr_q, buf_waddr_d;
  logic [31:0]      buf_data_q, buf_data_d;
  logic [3:0]       buf_mask_q, buf_mask_d;
  logic             err_q, err_d;

  logic [WordW-1:0] waddr;
  logic             legal;
  logic [31:0]      st_data;
  logic [3:0]       st_mask;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign waddr      = addr[ADDR_W-1:2];
  assign range_err  = (addr >> ADDR_W) != 32'd0;
  assign misalign   = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
                      (size == 2'b11);
  assign legal      = !misalign && !range_err;
  assign err_sticky = err_q;
  assign st_pending = buf_valid_q;

  // Buffer lanes are indexed by byte offset: lane i lives in bits [31-8i -: 8].
  always_comb begin
    st_data = data;
    st_mask = 4'b1111;
    case (size)
      2'b00: begin
        st_data = {4{data[7:0]}};
        st_mask = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{data[15:0]}};
        st_mask = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    buf_valid_d = MemWrite && legal;
    buf_waddr_d = buf_waddr_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    if (buf_valid_d) begin
      buf_waddr_d = waddr;
      buf_data_d  = st_data;
      buf_mask_d  = st_mask;
    end
    err_d = err_q;
    if ((MemRead || MemWrite) && !legal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_waddr_q <= '0;
      buf_data_q  <= '0;
      buf_mask_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_waddr_q <= buf_waddr_d;
      buf_data_q  <= buf_data_d;
      buf_mask_q  <= buf_mask_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_valid_q) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_mask_q[i]) begin
          mem_q[{buf_waddr_q, 2'(i)}] <= buf_data_q[31-8*i -: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (buf_valid_q && buf_waddr_q == waddr && buf_mask_q[i]) begin
        rd_word[31-8*i -: 8] = buf_data_q[31-8*i -: 8];
      end else begin
        rd_word[31-8*i -: 8] = mem_q[{waddr, 2'(i)}];
      end
    end
    rd_byte = 8'(rd_word >> {~addr[1:0], 3'b000});
    rd_half = addr[1] ? rd_word[15:0] : rd_word[31:16];
    case (size)
      2'b00:   DM_data = {{24{!ld_unsigned && rd_byte[7]}}, rd_byte};
      2'b01:   DM_data = {{16{!ld_unsigned && rd_half[15]}}, rd_half};
      2'b10:   DM_data = rd_word;
      default: DM_data = '0;
    endcase
    if (!MemRead || !legal) begin
      DM_data = '0;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: inputs change and outputs are checked on the negedge.
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, data;
  logic        MemRead, MemWrite, ld_unsigned, err_clr;
  logic [1:0]  size;
  logic [31:0] DM_data;
  logic        misalign, range_err, err_sticky, st_pending;

  int n_cmp = 0;
  int n_bad = 0;

  data_memory_sized #(.ADDR_W(7), .ZERO_INIT(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .data       (data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .size       (size),
    .ld_unsigned(ld_unsigned),
    .err_clr    (err_clr),
    .DM_data    (DM_data),
    .misalign   (misalign),
    .range_err  (range_err),
    .err_sticky (err_sticky),
    .st_pending (st_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setin(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input logic uns);
    MemRead     = rd;
    MemWrite    = wr;
    size        = sz;
    addr        = a;
    data        = d;
    ld_unsigned = uns;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    err_clr = 1'b0;
    setin(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_st_pending", {31'd0, st_pending}, 32'd0);
    check("reset_err_sticky", {31'd0, err_sticky}, 32'd0);
    check("reset_dm_idle", DM_data, 32'h0);
    tick();

    // Word store, forwarded byte load, then same load from the array.
    setin(1'b0, 1'b1, 2'b10, 32'h08, 32'h11223344, 1'b0);
    #1 check("word_st_misalign", {31'd0, misalign}, 32'd0);
    tick();
    setin(1'b1, 1'b0, 2'b00, 32'h09, 32'h0, 1'b1);
    #1 check("fwd_byte_09", DM_data, 32'h00000022);
    check("fwd_pending", {31'd0, st_pending}, 32'd1);
    tick();
    setin(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    setin(1'b1, 1'b0, 2'b00, 32'h09, 32'h0, 1'b1);
    #1 check("arr_byte_09", DM_data, 32'h00000022);
    check("arr_pending", {31'd0, st_pending}, 32'd0);
    tick();
    // Read and write together: load sees pre-store data.
    setin(1'b1, 1'b1, 2'b10, 32'h08, 32'h99887766, 1'b0);
    #1 check("rw_same_cycle", DM_data, 32'h11223344);
    tick();
    setin(1'b1, 1'b0, 2'b10, 32'h08, 32'h0, 1'b1);
    #1 check("rw_after", DM_data, 32'h99887766);
    tick();

    // Byte and half stores with sign/zero extension.
    setin(1'b0, 1'b1, 2'b00, 32'h10, 32'h12345680, 1'b0);
    tick();
    setin(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    #1 check("byte_signed", DM_data, 32'hFFFFFF80);
    ld_unsigned = 1'b1;
    #1 check("byte_unsigned", DM_data, 32'h00000080);
    tick();
    setin(1'b0, 1'b1, 2'b01, 32'h12, 32'hABCD8001, 1'b0);
    tick();
    setin(1'b1, 1'b0, 2'b01, 32'h12, 32'h0, 1'b0);
    #1 check("half_signed", DM_data, 32'hFFFF8001);
    ld_unsigned = 1'b1;
    #1 check("half_unsigned", DM_data, 32'h00008001);
    setin(1'b1, 1'b0, 2'b00, 32'h13, 32'h0, 1'b1);
    #1 check("half_low_byte", DM_data, 32'h00000001);
    setin(1'b1, 1'b0, 2'b00, 32'h11, 32'h0, 1'b1);
    #1 check("byte_untouched", DM_data, 32'h00000000);
    tick();

    // Back-to-back stores merging through the buffer.
    setin(1'b0, 1'b1, 2'b10, 32'h20, 32'hAABBCCDD, 1'b0);
    tick();
    setin(1'b0, 1'b1, 2'b00, 32'h22, 32'h00000055, 1'b0);
    tick();
    setin(1'b1, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0);
    #1 check("merge_fwd", DM_data, 32'hAABB55DD);
    check("merge_pending", {31'd0, st_pending}, 32'd1);
    tick();
    #1 check("merge_commit", DM_data, 32'hAABB55DD);
    check("merge_done", {31'd0, st_pending}, 32'd0);
    tick();

    // Misaligned accesses and sticky error behaviour.
    setin(1'b0, 1'b1, 2'b10, 32'h04, 32'h01020304, 1'b0);
    tick();
    setin(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    tick();
    setin(1'b0, 1'b1, 2'b10, 32'h06, 32'hDEADBEEF, 1'b0);
    #1 check("mis_st_flag", {31'd0, misalign}, 32'd1);
    check("mis_st_range", {31'd0, range_err}, 32'd0);
    tick();
    setin(1'b1, 1'b0, 2'b10, 32'h06, 32'h0, 1'b0);
    #1 check("mis_ld_data", DM_data, 32'h0);
    check("mis_err_set", {31'd0, err_sticky}, 32'd1);
    check("mis_dropped", {31'd0, st_pending}, 32'd0);
    tick();
    setin(1'b1, 1'b0, 2'b10, 32'h04, 32'h0, 1'b0);
    #1 check("mis_mem_intact", DM_data, 32'h01020304);
    tick();
    setin(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    err_clr = 1'b1;
    #1 check("clr_before_edge", {31'd0, err_sticky}, 32'd1);
    tick();
    #1 check("clr_after_edge", {31'd0, err_sticky}, 32'd0);
    setin(1'b1, 1'b0, 2'b01, 32'h13, 32'h0, 1'b0);
    #1 check("half_odd_mis", {31'd0, misalign}, 32'd1);
    check("half_odd_data", DM_data, 32'h0);
    tick();
    #1 check("set_wins_clr", {31'd0, err_sticky}, 32'd1);
    setin(1'b1, 1'b0, 2'b11, 32'h00, 32'h0, 1'b0);
    #1 check("size11_mis", {31'd0, misalign}, 32'd1);
    setin(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    tick();
    err_clr = 1'b0;

    // Out-of-range word store and load.
    #1 check("range_pre_clr", {31'd0, err_sticky}, 32'd0);
    setin(1'b0, 1'b1, 2'b10, 32'h80, 32'hCAFEF00D, 1'b0);
    #1 check("range_flag", {31'd0, range_err}, 32'd1);
    check("range_not_mis", {31'd0, misalign}, 32'd0);
    tick();
    setin(1'b1, 1'b0, 2'b10, 32'h80, 32'h0, 1'b0);
    #1 check("range_ld_data", DM_data, 32'h0);
    check("range_dropped", {31'd0, st_pending}, 32'd0);
    check("range_err_set", {31'd0, err_sticky}, 32'd1);
    tick();
    setin(1'b1, 1'b0, 2'b10, 32'h00, 32'h0, 1'b0);
    #1 check("range_no_alias", DM_data, 32'h0);
    tick();

    // Reset discards a pending store.
    setin(1'b0, 1'b1, 2'b10, 32'h30, 32'h12345678, 1'b0);
    tick();
    setin(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    #1 check("rst_pre_pending", {31'd0, st_pending}, 32'd1);
    rst_n = 1'b0;
    #1 check("rst_async_pending", {31'd0, st_pending}, 32'd0);
    check("rst_async_err", {31'd0, err_sticky}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    setin(1'b1, 1'b0, 2'b10, 32'h30, 32'h0, 1'b0);
    #1 check("rst_discarded", DM_data, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
